// File: rtl/fft_sample_loader.sv
// Feeds signed ADC samples into the FFT's 16-entry shift buffer, one write strobe
// per sample, then pulses frame_start and stalls input until the FFT finishes.
module fft_sample_loader #(
    parameter int N_SAMP = 16,
    parameter int IN_W   = 12,
    parameter int DW     = 16,
    parameter int AW     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   data,
    output logic            we,
    output logic            frame_start,
    input  logic            fft_done,
    output logic            busy,
    output logic [7:0]      frame_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FLUSH,
        ST_START,
        ST_WAIT
    } state_t;

    localparam int            SHIFT    = DW - IN_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMP - 1);

    state_t          state_q;
    logic [AW-1:0]   count_q;
    logic            s_ready_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic            frame_start_q;
    logic            busy_q;
    logic [7:0]      frame_cnt_q;

    // Sign-extend first, then shift: the extension bits fall off the top and the
    // sample ends up MSB-aligned with zero LSBs. Works unchanged for IN_W == DW.
    logic signed [DW-1:0] sext;
    logic        [DW-1:0] data_d;

    assign sext   = DW'($signed(s_data));
    assign data_d = sext << SHIFT;

    // NOTE: all state below uses non-blocking assignments so every register in
    // this block samples the same pre-edge values; blocking here would create
    // order-dependent races between state_q, count_q and the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            count_q       <= '0;
            s_ready_q     <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            // Strobes default low so each is exactly one cycle wide.
            we_q          <= 1'b0;
            frame_start_q <= 1'b0;

            case (state_q)
                ST_LOAD: begin
                    if (s_valid && s_ready_q) begin
                        we_q   <= 1'b1;
                        addr_q <= count_q;
                        data_q <= data_d;
                        busy_q <= 1'b1;
                        if (count_q == LAST_IDX) begin
                            count_q   <= '0;
                            s_ready_q <= 1'b0;
                            state_q   <= ST_FLUSH;
                        end else begin
                            count_q <= count_q + AW'(1);
                        end
                    end
                end

                // Last strobe is live this cycle; the buffer's outputs settle at
                // the closing edge, so frame_start is raised for the next cycle.
                ST_FLUSH: begin
                    frame_start_q <= 1'b1;
                    frame_cnt_q   <= frame_cnt_q + 8'd1;
                    state_q       <= ST_START;
                end

                ST_START: begin
                    state_q <= ST_WAIT;
                end

                // fft_done only counts here; earlier pulses are deliberately lost.
                ST_WAIT: begin
                    if (fft_done) begin
                        busy_q    <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end

                default: begin
                    state_q   <= ST_LOAD;
                    count_q   <= '0;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign we          = we_q;
    assign addr        = addr_q;
    assign data        = data_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Upstream feeder for the 16-entry sample shift buffer in front of the 16-point FFT.
- Accepts a stream of signed ADC samples over a valid/ready handshake and sign-extends/left-aligns each one to 16 bits.
- Issues one write strobe per sample into the buffer and, after 16 samples, pulses a frame-start to the FFT.
- Then holds off input until the FFT reports completion, so a frame is never overwritten while being transformed.

Parameters:
- N_SAMP, 16: samples per frame; must be a power of 2, at most 16.
- IN_W, 12: input sample width, signed two's complement, 2..16.
- DW, 16: output data width to the buffer.
- AW, 4: buffer address width, log2(N_SAMP).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- s_data  in  IN_W  input sample, signed.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader can accept a sample this cycle.
- addr  out  AW  write index of the sample being written (0..N_SAMP-1).
- data  out  DW  converted sample to the buffer.
- we  out  1  one-cycle write strobe per accepted sample.
- frame_start  out  1  one-cycle pulse: all buffer parallel outputs hold a complete frame.
- fft_done  in  1  one-cycle pulse from the FFT: frame consumed.
- busy  out  1  high from the first accepted sample of a frame until fft_done is accepted.
- frame_cnt  out  8  frames handed off, wraps 255->0.

Behaviour:
- Reset (rst_n=0 at a posedge): state=LOAD, count=0, we=0, addr=0, data=0, frame_start=0, busy=0, frame_cnt=0.
- Reset has priority over everything, including mid-frame. A partially loaded frame is abandoned and the next frame restarts at addr 0. Stale buffer contents are not cleared.
- States:
  - LOAD: s_ready=1. A transfer occurs on a posedge with s_valid=1.
    - On a transfer, in the next cycle: we=1, addr=count, data=conversion of s_data. count increments and busy=1.
    - No transfer: we=0 next cycle; data and addr hold.
    - Transfer with count==N_SAMP-1: count->0, state->FLUSH.
  - FLUSH (1 cycle): s_ready=0. The last write strobe is active in this cycle. The buffer writes on its negedge and registers its parallel outputs at the closing posedge. state->START.
  - START (1 cycle): s_ready=0, we=0, frame_start=1, frame_cnt increments. state->WAIT.
  - WAIT: s_ready=0, we=0. Stays until fft_done=1 at a posedge, then state->LOAD and busy=0.
- fft_done is sampled only in WAIT. Pulses in LOAD/FLUSH/START are ignored and not remembered.
- s_valid while s_ready=0 is not a transfer. The source must hold s_data/s_valid; the loader never drops or duplicates a sample.
- Conversion: data = s_data sign-extended to DW and shifted left by (DW-IN_W), i.e. MSB-aligned, LSBs zero. With IN_W=DW, data = s_data.
- Latency:
  - Accept edge -> we high in the following cycle (1 cycle).
  - 16th accept edge -> frame_start high 2 cycles later.
  - fft_done edge -> s_ready high in the next cycle.
- Back-to-back input gives 16 consecutive we cycles. Minimum frame period is N_SAMP+2 cycles plus FFT time.
- Buffer order: the buffer shifts toward index 0, so the first accepted sample of a frame lands in buffer slot 0 and the last in slot 15. addr is informational for the buffer and must still be correct.
- frame_start and we are never high in the same cycle.

Test Plan:
- Reset then 16 back-to-back samples 0x001..0x010 (IN_W=12):
  - we is high for 16 consecutive cycles, addr 0..15, data 0x0010..0x0100.
  - frame_start pulses exactly 2 cycles after the 16th accept; the buffer shows slot0=0x0010 and slot15=0x0100.
  - s_ready stays 0 until fft_done.
- Conversion corners: s_data 0x800 -> data 0x8000; 0x7FF -> 0x7FF0; 0xFFF -> 0xFFF0; 0x000 -> 0x0000.
- Gappy s_valid (random 50%): exactly 16 we pulses, in order, with no duplicates. A sample held across a WAIT stall is accepted exactly once after fft_done.
- fft_done pulsed during LOAD (count=7) and during START: ignored, state unchanged. fft_done in WAIT: s_ready=1 next cycle, busy=0, and a new frame starts at addr 0.
- rst_n low at count=9: all outputs return to reset values the next cycle, frame_cnt=0. The following 16 samples produce frame_start with addr restarting at 0.
- 257 full frames: frame_cnt wraps 255->0 then reads 1, with one frame_start per frame.
